// File: rtl/blink_led_sched.sv
// rtl/blink_led_sched.sv - round-robin scheduler sharing one LED register between NREQ blink requesters
module blink_led_sched #(
    parameter int NREQ       = 4,
    parameter int CNT_W      = 32,
    parameter int ON_CYCLES  = 5000000,
    parameter int OFF_CYCLES = 5000000,
    parameter int BLK_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*BLK_W-1:0] req_count,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  led_in,
    output logic                  led_we
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_ON   = 3'd2;
    localparam logic [2:0] S_OFF  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic             led_in_q, led_in_d;
    logic             led_we_q, led_we_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [BLK_W-1:0] remaining_q, remaining_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [BLK_W-1:0] pick_cnt;
    int               j;

    // Scan starts just past the last served requester and wraps around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_cnt   = '0;
        j          = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(rr_q) + k) % NREQ;
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
                pick_cnt   = req_count[j*BLK_W +: BLK_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        busy_d      = busy_q;
        led_we_d    = 1'b0;
        led_in_d    = 1'b0;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end
            S_ARB: begin
                if (!pick_found) begin
                    state_d = S_IDLE;
                end else begin
                    owner_d     = pick_idx;
                    grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    busy_d      = 1'b1;
                    remaining_d = pick_cnt;
                    if (pick_cnt == '0) begin
                        state_d = S_FIN;
                    end else begin
                        led_we_d = 1'b1;
                        led_in_d = 1'b1;
                        timer_d  = ON_LOAD;
                        state_d  = S_ON;
                    end
                end
            end
            S_ON: begin
                if (!req[owner_q]) begin
                    led_we_d = 1'b1;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    timer_d  = '0;
                    state_d  = S_FIN;
                end else if (timer_q == '0) begin
                    led_we_d = 1'b1;
                    timer_d  = OFF_LOAD;
                    state_d  = S_OFF;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            S_OFF: begin
                if (!req[owner_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    timer_d = '0;
                    state_d = S_FIN;
                end else if (timer_q == '0) begin
                    if (remaining_q == BLK_W'(1)) begin
                        remaining_d = '0;
                        done_d      = grant_q;
                        grant_d     = '0;
                        busy_d      = 1'b0;
                        state_d     = S_FIN;
                    end else begin
                        remaining_d = remaining_q - BLK_W'(1);
                        led_we_d    = 1'b1;
                        led_in_d    = 1'b1;
                        timer_d     = ON_LOAD;
                        state_d     = S_ON;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            S_FIN: begin
                // Still busy here only for a zero-count grant, which completes now.
                if (busy_q) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
                rr_d    = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            led_in_q    <= 1'b0;
            led_we_q    <= 1'b0;
            timer_q     <= '0;
            remaining_q <= '0;
            rr_q        <= IDX_W'(NREQ - 1);
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            led_in_q    <= led_in_d;
            led_we_q    <= led_we_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign led_in = led_in_q;
    assign led_we = led_we_q;
endmodule

// File: tb/tb_blink_led_sched.sv
// tb/tb_blink_led_sched.sv - directed and randomized bench for blink_led_sched with a timeline reference model
module tb_blink_led_sched;
    localparam int NREQ  = 4;
    localparam int BLK_W = 8;
    localparam int ON    = 4;
    localparam int OFF   = 3;
    localparam int P     = ON + OFF;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*BLK_W-1:0] req_count = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  led_in;
    logic                  led_we;

    int total = 0;
    int bad   = 0;
    int rr_m  = NREQ - 1;

    blink_led_sched #(
        .NREQ(NREQ), .CNT_W(32), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .BLK_W(BLK_W)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_count(req_count),
        .grant(grant), .done(done), .busy(busy), .led_in(led_in), .led_we(led_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                             input logic eb, input logic ew, input logic ei);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".led_we"}, 32'(led_we), 32'(ew));
        chk({tag, ".led_in"}, 32'(led_in), 32'(ei));
    endtask

    task automatic idle_cycles(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            check_out(tag, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic set_count(input int i, input int v);
        req_count[i*BLK_W +: BLK_W] = BLK_W'(v);
    endtask

    function automatic int next_owner(input int rr, input logic [3:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Timeline of one service starting at its grant edge: on-writes every P cycles,
    // off-writes ON cycles later, done after n full periods; abort ends it one cycle after the drop.
    task automatic expect_service(input string tag, input int g, input int n, input int a, input bit hold);
        logic [3:0] oh;
        int end_rel;
        oh = 4'b0001 << g;
        if (n == 0)      end_rel = 1;
        else if (a >= 0) end_rel = a + 1;
        else             end_rel = n * P;
        for (int rel = 0; rel <= end_rel; rel++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                if (rel == 0) check_out(tag, oh, 4'b0, 1'b1, 1'b0, 1'b0);
                else          check_out(tag, 4'b0, oh, 1'b0, 1'b0, 1'b0);
            end else if (rel == end_rel) begin
                if (a >= 0) check_out(tag, 4'b0, 4'b0, 1'b0, (a % P) < ON, 1'b0);
                else        check_out(tag, 4'b0, oh, 1'b0, 1'b0, 1'b0);
            end else begin
                check_out(tag, oh, 4'b0, 1'b1, (rel % P == 0) || (rel % P == ON), rel % P == 0);
            end
            if (rel == a) req[g] = 1'b0;
            if (rel == end_rel && !hold) req[g] = 1'b0;
        end
    endtask

    initial begin
        int g;
        logic [3:0] mask;
        logic [3:0] pending;
        int cnt [NREQ];

        #1;
        check_out("reset_async", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_hold", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle_cycles(2, "idle_no_req");

        for (int i = 0; i < NREQ; i++) set_count(i, 1);
        req = 4'hf;
        idle_cycles(1, "rr_start");
        for (int k = 0; k < 5; k++) begin
            g = next_owner(rr_m, req);
            expect_service("round_robin", g, 1, -1, 1'b1);
            rr_m = g;
            if (k < 4) idle_cycles(2, "rr_gap");
        end
        req = 4'h0;
        idle_cycles(3, "rr_end");

        set_count(0, 2);
        req = 4'b0001;
        idle_cycles(1, "single_arb");
        expect_service("single", 0, 2, -1, 1'b0);
        rr_m = 0;
        idle_cycles(3, "single_end");

        set_count(2, 0);
        req = 4'b0100;
        idle_cycles(1, "zero_arb");
        expect_service("zero_count", 2, 0, -1, 1'b0);
        rr_m = 2;
        idle_cycles(3, "zero_end");

        set_count(1, 3);
        req = 4'b0010;
        idle_cycles(1, "abort_on_arb");
        expect_service("abort_on", 1, 3, 2, 1'b0);
        rr_m = 1;
        idle_cycles(3, "abort_on_end");

        req = 4'b0010;
        idle_cycles(1, "abort_exp_arb");
        expect_service("abort_expiry", 1, 3, P - 1, 1'b0);
        idle_cycles(3, "abort_exp_end");

        set_count(3, 255);
        req = 4'b1000;
        idle_cycles(1, "c255_arb");
        expect_service("count255", 3, 255, -1, 1'b0);
        rr_m = 3;
        idle_cycles(3, "c255_end");

        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] = int'($urandom_range(0, 2));
                set_count(i, cnt[i]);
            end
            req = mask;
            pending = mask;
            idle_cycles(1, "rand_arb");
            while (pending != 4'b0) begin
                g = next_owner(rr_m, pending);
                expect_service("rand", g, cnt[g], -1, 1'b0);
                pending[g] = 1'b0;
                rr_m = g;
                if (pending != 4'b0) idle_cycles((cnt[g] == 0) ? 1 : 2, "rand_gap");
            end
            idle_cycles(3, "rand_end");
        end

        set_count(1, 1);
        req = 4'b0010;
        idle_cycles(1, "pre_rst_arb");
        expect_service("pre_reset", 1, 1, -1, 1'b0);
        rr_m = 1;
        idle_cycles(3, "pre_rst_end");

        set_count(0, 3);
        req = 4'b0001;
        idle_cycles(1, "rst_arb");
        @(posedge clk);
        #1;
        check_out("rst_on0", 4'b0001, 4'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_out("rst_on1", 4'b0001, 4'b0, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_out("rst_mid_on", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        req = 4'b0;
        @(posedge clk);
        #1;
        check_out("rst_held", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        set_count(1, 1);
        set_count(3, 1);
        reset = 1'b1;
        req = 4'b1010;
        rr_m = NREQ - 1;
        idle_cycles(1, "post_rst_arb");
        g = next_owner(rr_m, req);
        expect_service("post_reset_first", g, 1, -1, 1'b0);
        rr_m = g;
        idle_cycles(2, "post_rst_gap");
        g = next_owner(rr_m, req);
        expect_service("post_reset_second", g, 1, -1, 1'b0);
        idle_cycles(3, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
